clkdiv_frac_mc: RTL and testbench

Multi-channel integer+fractional clock-enable generator; each channel emits single-cycle clk_en pulses at an average of div_int + div_frac/2^W_DIV_FRAC clk cycles. Each channel selects 1st-order (single accumulator) or 2nd-order (MASH 1-1) delta-sigma pulse swallowing. A global resync input phase-aligns all channels. It drives UART, PWM, audio and sample-rate timing from one system clock.

---
 rtl/clkdiv_pkg.sv | 17 +
 rtl/clkdiv_frac_ch.sv | 115 +++++++++++
 rtl/clkdiv_frac_mc.sv | 38 +++
 tb/tb_clkdiv_frac_mc.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and widths for the fractional clock-enable divider.
// Order encoding, counter width helper and correction width live here.
package clkdiv_pkg;

  typedef enum logic {
    ORDER_1ST = 1'b0,
    ORDER_2ND = 1'b1
  } order_e;

  // Signed period correction spans -1..+2.
  localparam int W_CORR = 3;

  function automatic int ctr_width(input int w_div_int);
    return w_div_int + 1;
  endfunction

endpackage

// File: rtl/clkdiv_frac_ch.sv
// One divider channel: period counter plus 1st-order or MASH 1-1 noise shaper
// that picks the length of the next period at each period boundary.
module clkdiv_frac_ch
  import clkdiv_pkg::*;
#(
  parameter int W_DIV_INT  = 16,
  parameter int W_DIV_FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  order,
  input  logic                  resync,
  input  logic [W_DIV_INT-1:0]  div_int,
  input  logic [W_DIV_FRAC-1:0] div_frac,
  output logic                  clk_en
);

  localparam int W_CTR = ctr_width(W_DIV_INT);
  localparam int W_P   = W_DIV_INT + 2;

  logic [W_CTR-1:0]      ctr_q, ctr_d;
  logic [W_DIV_FRAC-1:0] acc1_q, acc1_d;
  logic [W_DIV_FRAC-1:0] acc2_q, acc2_d;
  logic                  c2_prev_q, c2_prev_d;
  logic                  clk_en_q, clk_en_d;

  logic                  boundary;
  logic                  is_2nd;
  logic [W_DIV_INT-1:0]  div_eff;
  logic [W_DIV_FRAC:0]   sum1;
  logic [W_DIV_FRAC:0]   sum2;
  logic                  c1;
  logic                  c2;
  logic [W_DIV_FRAC-1:0] acc1_nx;
  logic [W_DIV_FRAC-1:0] acc2_nx;
  logic [W_CORR-1:0]     corr;
  logic [W_P-1:0]        period;
  logic                  period_clamp;
  logic [W_CTR-1:0]      ctr_reload;

  assign boundary = (ctr_q == W_CTR'(1));
  assign is_2nd   = (order_e'(order) == ORDER_2ND);

  // Noise shaper datapath, only consumed at a period boundary.
  always_comb begin
    div_eff = (div_int == '0) ? W_DIV_INT'(1) : div_int;

    sum1    = {1'b0, acc1_q} + {1'b0, div_frac};
    c1      = sum1[W_DIV_FRAC];
    acc1_nx = sum1[W_DIV_FRAC-1:0];

    sum2    = {1'b0, acc2_q} + {1'b0, acc1_nx};
    c2      = sum2[W_DIV_FRAC];
    acc2_nx = sum2[W_DIV_FRAC-1:0];

    if (is_2nd) begin
      corr = {2'b00, c1} + {2'b00, c2} - {2'b00, c2_prev_q};
    end else begin
      corr = {2'b00, c1};
    end

    // Sign-extend the correction into the wider period sum.
    period       = {2'b00, div_eff} + {{(W_P-W_CORR){corr[W_CORR-1]}}, corr};
    period_clamp = period[W_P-1] || (period == '0);
    ctr_reload   = period_clamp ? W_CTR'(1) : period[W_CTR-1:0];
  end

  always_comb begin
    ctr_d     = ctr_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    c2_prev_d = c2_prev_q;
    clk_en_d  = 1'b0;

    if (!en || resync) begin
      ctr_d     = W_CTR'(1);
      acc1_d    = '0;
      acc2_d    = '0;
      c2_prev_d = 1'b0;
    end else if (boundary) begin
      clk_en_d = 1'b1;
      ctr_d    = ctr_reload;
      acc1_d   = acc1_nx;
      if (is_2nd) begin
        acc2_d    = acc2_nx;
        c2_prev_d = c2;
      end else begin
        acc2_d    = '0;
        c2_prev_d = 1'b0;
      end
    end else begin
      ctr_d = ctr_q - W_CTR'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr_q     <= W_CTR'(1);
      acc1_q    <= '0;
      acc2_q    <= '0;
      c2_prev_q <= 1'b0;
      clk_en_q  <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      c2_prev_q <= c2_prev_d;
      clk_en_q  <= clk_en_d;
    end
  end

  assign clk_en = clk_en_q;

endmodule

// File: rtl/clkdiv_frac_mc.sv
// Multi-channel fractional clock-enable generator: one independent channel
// per lane, sharing only the clock, reset and the global resync strobe.
module clkdiv_frac_mc
  import clkdiv_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int W_DIV_INT  = 16,
  parameter int W_DIV_FRAC = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH-1:0]              en,
  input  logic [N_CH-1:0]              order,
  input  logic [N_CH*W_DIV_INT-1:0]    div_int,
  input  logic [N_CH*W_DIV_FRAC-1:0]   div_frac,
  input  logic                         resync,
  output logic [N_CH-1:0]              clk_en
);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      clkdiv_frac_ch #(
        .W_DIV_INT (W_DIV_INT),
        .W_DIV_FRAC(W_DIV_FRAC)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .en      (en[gi]),
        .order   (order[gi]),
        .resync  (resync),
        .div_int (div_int[gi*W_DIV_INT +: W_DIV_INT]),
        .div_frac(div_frac[gi*W_DIV_FRAC +: W_DIV_FRAC]),
        .clk_en  (clk_en[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clkdiv_frac_mc.sv
// Scoreboard bench: a boundary-time model predicts pulse cycles per channel,
// a negedge monitor matches DUT pulses against them; directed phases add span/gap checks.
module tb_clkdiv_frac_mc;

  localparam int N_CH = 2;
  localparam int WI   = 16;
  localparam int WF   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_CH-1:0]    en;
  logic [N_CH-1:0]    order;
  logic [N_CH*WI-1:0] div_int;
  logic [N_CH*WF-1:0] div_frac;
  logic               resync;
  logic [N_CH-1:0]    clk_en;

  always #5 clk = ~clk;

  clkdiv_frac_mc #(.N_CH(N_CH), .W_DIV_INT(WI), .W_DIV_FRAC(WF)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .order   (order),
    .div_int (div_int),
    .div_frac(div_frac),
    .resync  (resync),
    .clk_en  (clk_en)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int exp_q[N_CH][$];
  int pulse_log[N_CH][$];

  // Reference model: tracks the absolute cycle of the next boundary and the
  // fractional phase as plain integers.
  int m_armed[N_CH];
  int m_next[N_CH];
  int m_a1[N_CH];
  int m_a2[N_CH];
  int m_cp[N_CH];

  always @(posedge clk or posedge rst) begin : model
    int di, df, s1, c1, s2, c2, corr, p;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        m_armed[c] = 1; m_next[c] = 0; m_a1[c] = 0; m_a2[c] = 0; m_cp[c] = 0;
      end
    end else begin
      cyc = cyc + 1;
      for (int c = 0; c < N_CH; c++) begin
        di = int'(div_int[c*WI +: WI]);
        df = int'(div_frac[c*WF +: WF]);
        if (!en[c] || resync) begin
          m_armed[c] = 1; m_a1[c] = 0; m_a2[c] = 0; m_cp[c] = 0;
        end else if (m_armed[c] != 0 || cyc == m_next[c]) begin
          if (di == 0) di = 1;
          s1 = m_a1[c] + df;
          c1 = s1 / 256;
          m_a1[c] = s1 % 256;
          if (order[c]) begin
            s2 = m_a2[c] + m_a1[c];
            c2 = s2 / 256;
            m_a2[c] = s2 % 256;
            corr = c1 + c2 - m_cp[c];
            m_cp[c] = c2;
          end else begin
            corr = c1;
            m_a2[c] = 0;
            m_cp[c] = 0;
          end
          p = di + corr;
          if (p < 1) p = 1;
          m_next[c]  = cyc + p;
          m_armed[c] = 0;
          exp_q[c].push_back(cyc);
        end
      end
    end
  end

  // Monitor: every cycle where a pulse is expected or seen is one comparison.
  always @(negedge clk) begin : monitor
    int exp_now;
    if (rst === 1'b0) begin
      for (int c = 0; c < N_CH; c++) begin
        while (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
          total++; bad++;
          $display("FAIL stale_expect ch%0d: pulse required at cycle %0d never matched", c, exp_q[c][0]);
          void'(exp_q[c].pop_front());
        end
        exp_now = 0;
        if (exp_q[c].size() > 0 && exp_q[c][0] == cyc) begin
          exp_now = 1;
          void'(exp_q[c].pop_front());
        end
        if (clk_en[c] || exp_now != 0) begin
          total++;
          if (int'(clk_en[c]) != exp_now) begin
            bad++;
            $display("FAIL pulse ch%0d cycle %0d: got clk_en=%0d required %0d", c, cyc, clk_en[c], exp_now);
          end
        end
        if (clk_en[c]) pulse_log[c].push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    total++;
    if (got < lo || got > hi) begin
      bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic set_ch(input int c, input int e, input int o, input int d, input int f);
    en[c]                = e[0];
    order[c]             = o[0];
    div_int[c*WI +: WI]  = WI'(d);
    div_frac[c*WF +: WF] = WF'(f);
  endtask

  task automatic clear_logs();
    for (int c = 0; c < N_CH; c++) pulse_log[c].delete();
  endtask

  task automatic wait_log(input int c, input int n, input int limit);
    int k = 0;
    while (pulse_log[c].size() < n && k < limit) begin
      step(1);
      k++;
    end
    check("wait_pulses_timeout", (pulse_log[c].size() >= n) ? 1 : 0, 1);
  endtask

  // Restart ch0 from the cleared state with a new configuration and log 257 pulses.
  task automatic run_span(input string name, input int o, input int d, input int f,
                          input int span_req, input int gmin, input int gmax);
    int lo, hi, g;
    set_ch(0, 0, o, d, f);
    step(1);
    clear_logs();
    set_ch(0, 1, o, d, f);
    wait_log(0, 257, 3000);
    if (pulse_log[0].size() >= 257) begin
      lo = 1 << 30; hi = 0;
      for (int i = 1; i < 257; i++) begin
        g = pulse_log[0][i] - pulse_log[0][i-1];
        if (g < lo) lo = g;
        if (g > hi) hi = g;
      end
      check({name, "_span"}, pulse_log[0][256] - pulse_log[0][0], span_req);
      check_range({name, "_gap_min"}, lo, gmin, gmax);
      check_range({name, "_gap_max"}, hi, gmin, gmax);
    end
    $display("phase %s: order=%0d div=%0d frac=0x%02h", name, o, d, f);
  endtask

  initial begin
    int t0;
    rst = 1'b1; en = '0; order = '0; div_int = '0; div_frac = '0; resync = 1'b0;
    step(3);
    check("reset_clk_en", int'(clk_en), 0);
    rst = 1'b0;

    // Integer divide: first pulse one cycle after enable, then every 4.
    set_ch(0, 1, 0, 4, 0);
    clear_logs();
    step(1);
    check("int_first_latency", int'(clk_en[0]), 1);
    step(99);
    check("int_count_100", pulse_log[0].size(), 25);
    $display("phase integer: div=4 pulses=%0d", pulse_log[0].size());

    run_span("frac1", 0, 3, 8'h80, 896, 3, 4);
    check("frac1_gap0", pulse_log[0][1] - pulse_log[0][0], 3);
    check("frac1_gap1", pulse_log[0][2] - pulse_log[0][1], 4);
    run_span("mash40", 1, 4, 8'h40, 1088, 3, 6);
    run_span("mash01", 1, 4, 8'h01, 1025, 3, 6);

    // Mid-period divisor change only affects the following period.
    set_ch(0, 1, 0, 4, 0);
    step(10);
    clear_logs();
    wait_log(0, 1, 20);
    step(2);
    set_ch(0, 1, 0, 6, 0);
    wait_log(0, 3, 40);
    check("midchg_gap_cur", pulse_log[0][1] - pulse_log[0][0], 4);
    check("midchg_gap_next", pulse_log[0][2] - pulse_log[0][1], 6);
    $display("phase midchange: div 4->6");

    // div_int of 1 and 0 with zero fraction: continuously high.
    for (int d = 1; d >= 0; d--) begin
      set_ch(0, 1, 0, d, 0);
      step(8);
      for (int i = 0; i < 10; i++) begin
        check($sformatf("const_high_div%0d", d), int'(clk_en[0]), 1);
        step(1);
      end
      $display("phase const_high: div=%0d", d);
    end

    // Resync coincident with a ch0 boundary.
    set_ch(0, 1, 0, 5, 0);
    step(1);
    set_ch(1, 1, 0, 7, 0);
    step(3);
    set_ch(0, 1, 0, 5, 0);
    step(20);
    clear_logs();
    wait_log(0, 1, 20);
    step(4);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    check("resync_drop", int'(clk_en), 0);
    step(1);
    check("resync_aligned", int'(clk_en), 3);
    t0 = cyc;
    clear_logs();
    step(40);
    check("resync_ch0_gap", pulse_log[0][1] - pulse_log[0][0], 5);
    check("resync_ch1_gap", pulse_log[1][1] - pulse_log[1][0], 7);
    check("resync_ch0_first", pulse_log[0][0] - t0, 5);
    set_ch(1, 0, 0, 7, 0);
    resync = 1'b1;
    step(1);
    resync = 1'b0;
    clear_logs();
    step(20);
    check("disabled_ch1_quiet", pulse_log[1].size(), 0);
    $display("phase resync: ch0 div5 ch1 div7");

    // Asynchronous reset mid-operation.
    set_ch(0, 1, 0, 1, 0);
    step(5);
    rst = 1'b1;
    #1;
    check("async_reset_drop", int'(clk_en), 0);
    set_ch(0, 1, 0, 4, 0);
    step(3);
    rst = 1'b0;
    clear_logs();
    step(1);
    check("post_reset_first", int'(clk_en[0]), 1);
    step(12);
    check("post_reset_count", pulse_log[0].size(), 4);
    $display("phase reset: released with div=4");

    // Randomized traffic, scored entirely by the monitor.
    set_ch(0, 1, 1, 5, 8'h33);
    set_ch(1, 1, 0, 3, 8'hc1);
    for (int it = 0; it < 4000; it++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 99) < 4) begin
          div_int[c*WI +: WI]  = WI'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 9));
          div_frac[c*WF +: WF] = WF'($urandom_range(0, 255));
          order[c]             = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 299) == 0) en[c] = ~en[c];
      end
      resync = ($urandom_range(0, 249) == 0);
      step(1);
    end
    resync = 1'b0;
    $display("phase random: 4000 cycles");

    en = '0;
    step(3);
    for (int c = 0; c < N_CH; c++) check($sformatf("queue_drained_ch%0d", c), exp_q[c].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
